// File: rtl/memcpy_sched_pkg.sv
// memcpy_sched_pkg: shared scheduler state encoding and write-response line decode
package memcpy_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;
  function automatic logic [2:0] rsp_lines(input logic [1:0] code);
    return code == 2'd0 ? 3'd1 : code == 2'd1 ? 3'd2 : code == 2'd3 ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/memcpy_rsp_counter.sv
// memcpy_rsp_counter: accumulates acknowledged write lines and flags protocol violations
module memcpy_rsp_counter
  import memcpy_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_rsp_valid,
  input  logic [1:0]  i_rsp_cl_num,
  input  logic [31:0] i_num_lines,
  output logic [31:0] o_count,
  output logic        o_proto_err
);
  logic [31:0] r_count;
  logic        r_proto_err;
  logic        w_hit;
  assign w_hit = i_en && i_rsp_valid;
  assign o_count = r_count;
  assign o_proto_err = r_proto_err;
  // count lines per response; code 2 or an over-count latches the sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else if (i_clr) begin
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_hit) r_count <= r_count + 32'(rsp_lines(i_rsp_cl_num));
      if ((w_hit && i_rsp_cl_num == 2'd2) || (i_en && r_count > i_num_lines)) r_proto_err <= 1'b1;
    end
  end
endmodule

// File: rtl/memcpy_req_sched.sv
// memcpy_req_sched: issues cache-line reads for a copy job under an in-flight cap and reports completion
module memcpy_req_sched
  import memcpy_sched_pkg::*;
#(
  parameter int MAX_INFLIGHT = 62,
  parameter int ADDR_W       = 42
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_status_addr,
  input  logic [31:0]       i_num_lines,
  input  logic              i_c0_alm_full,
  input  logic              i_c1_alm_full,
  input  logic              i_wr_rsp_valid,
  input  logic [1:0]        i_wr_rsp_cl_num,
  output logic              o_rd_req_valid,
  output logic [ADDR_W-1:0] o_rd_req_addr,
  output logic [15:0]       o_rd_req_mdata,
  output logic              o_rpt_valid,
  input  logic              i_rpt_ready,
  output logic [ADDR_W-1:0] o_rpt_addr,
  output logic [63:0]       o_rpt_cycles,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_start_err,
  output logic              o_proto_err,
  output logic [31:0]       o_issued_cnt,
  output logic [31:0]       o_completed_cnt
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_src, r_status, r_rd_addr;
  logic [31:0]       r_num, r_issued;
  logic [63:0]       r_cycles;
  logic [15:0]       r_rd_mdata;
  logic              r_rd_valid, r_done, r_start_err;
  logic [31:0]       w_completed;
  logic              w_accept, w_issue, w_active, w_abort;
  assign w_abort  = i_abort && r_state != IDLE;
  assign w_active = r_state == RUN || r_state == DRAIN;
  assign w_accept = r_state == IDLE && i_start && !i_abort && |i_num_lines && |i_src_addr && |i_status_addr;
  assign w_issue  = r_state == RUN && !i_abort && !i_c0_alm_full && !i_c1_alm_full &&
                    (r_issued - w_completed) < 32'(MAX_INFLIGHT) && r_issued < r_num;
  memcpy_rsp_counter u_rsp (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_accept),
    .i_en         (w_active),
    .i_rsp_valid  (i_wr_rsp_valid),
    .i_rsp_cl_num (i_wr_rsp_cl_num),
    .i_num_lines  (r_num),
    .o_count      (w_completed),
    .o_proto_err  (o_proto_err)
  );
  assign o_rd_req_valid  = r_rd_valid;
  assign o_rd_req_addr   = r_rd_addr;
  assign o_rd_req_mdata  = r_rd_mdata;
  assign o_rpt_valid     = r_state == REPORT;
  assign o_rpt_addr      = r_status;
  assign o_rpt_cycles    = r_cycles;
  assign o_busy          = r_state != IDLE;
  assign o_done          = r_done;
  assign o_start_err     = r_start_err;
  assign o_issued_cnt    = r_issued;
  assign o_completed_cnt = w_completed;
  // job FSM: issue, drain, report; abort from any busy state returns to IDLE keeping counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_src       <= '0;
      r_status    <= '0;
      r_num       <= '0;
      r_issued    <= '0;
      r_cycles    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_mdata  <= '0;
      r_done      <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_rd_valid  <= w_issue;
      r_done      <= r_state == REPORT && i_rpt_ready && !i_abort;
      r_start_err <= i_start && (r_state != IDLE || (!i_abort && !w_accept));
      if (w_issue) begin
        r_rd_addr  <= r_src + ADDR_W'(r_issued);
        r_rd_mdata <= r_issued[15:0];
        r_issued   <= r_issued + 32'd1;
      end
      if (w_active && ~&r_cycles) r_cycles <= r_cycles + 64'd1;
      if (w_abort) r_state <= IDLE;
      else begin
        case (r_state)
          IDLE: if (w_accept) begin
            r_state  <= RUN;
            r_src    <= i_src_addr;
            r_status <= i_status_addr;
            r_num    <= i_num_lines;
            r_issued <= '0;
            r_cycles <= '0;
          end
          RUN:     if (w_issue && r_issued + 32'd1 == r_num) r_state <= DRAIN;
          DRAIN:   if (w_completed >= r_num) r_state <= REPORT;
          REPORT:  if (i_rpt_ready) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_memcpy_req_sched.sv
// tb_memcpy_req_sched: randomized and directed checks of the copy scheduler against a job-level model
module tb_memcpy_req_sched;
  localparam int AW   = 42;
  localparam int MAXI = 62;
  logic clk = 0, rst_n = 0;
  logic start = 0, abort = 0, alm0 = 0, alm1 = 0, rsp_v = 0, ready = 0;
  logic [1:0] rsp_cl = 0;
  logic [AW-1:0] src = 0, stat = 0;
  logic [31:0] num = 0;
  logic rd_v, rpt_v, busy, done, serr, perr;
  logic [AW-1:0] rd_addr, rpt_addr;
  logic [15:0] rd_md;
  logic [63:0] rpt_cyc;
  logic [31:0] iss, cmp;
  logic s_rd_v, s_rpt_v, s_busy, s_done, s_serr, s_perr;
  logic [AW-1:0] s_rd_addr, s_rpt_addr;
  logic [15:0] s_rd_md;
  logic [63:0] s_rpt_cyc;
  logic [31:0] s_iss, s_cmp;
  int checks = 0, errors = 0;
  int m_ph;
  logic [AW-1:0] m_src, m_stat, e_addr;
  longint m_num, m_iss, m_cmp;
  logic [63:0] m_cyc;
  logic m_perr, e_rv, e_done, e_serr;
  logic [15:0] e_md;

  always #5 clk = ~clk;

  memcpy_req_sched #(.MAX_INFLIGHT(MAXI), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_src_addr(src), .i_status_addr(stat),
    .i_num_lines(num), .i_c0_alm_full(alm0), .i_c1_alm_full(alm1), .i_wr_rsp_valid(rsp_v),
    .i_wr_rsp_cl_num(rsp_cl), .o_rd_req_valid(rd_v), .o_rd_req_addr(rd_addr), .o_rd_req_mdata(rd_md),
    .o_rpt_valid(rpt_v), .i_rpt_ready(ready), .o_rpt_addr(rpt_addr), .o_rpt_cycles(rpt_cyc),
    .o_busy(busy), .o_done(done), .o_start_err(serr), .o_proto_err(perr),
    .o_issued_cnt(iss), .o_completed_cnt(cmp));

  memcpy_req_sched #(.MAX_INFLIGHT(2), .ADDR_W(AW)) u_small (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_src_addr(src), .i_status_addr(stat),
    .i_num_lines(num), .i_c0_alm_full(alm0), .i_c1_alm_full(alm1), .i_wr_rsp_valid(rsp_v),
    .i_wr_rsp_cl_num(rsp_cl), .o_rd_req_valid(s_rd_v), .o_rd_req_addr(s_rd_addr), .o_rd_req_mdata(s_rd_md),
    .o_rpt_valid(s_rpt_v), .i_rpt_ready(ready), .o_rpt_addr(s_rpt_addr), .o_rpt_cycles(s_rpt_cyc),
    .o_busy(s_busy), .o_done(s_done), .o_start_err(s_serr), .o_proto_err(s_perr),
    .o_issued_cnt(s_iss), .o_completed_cnt(s_cmp));

  function automatic int lines_of(input logic [1:0] c);
    return c == 2'd0 ? 1 : c == 2'd1 ? 2 : c == 2'd3 ? 4 : 0;
  endfunction

  // job-level model of the default instance, advanced across one clock edge
  task automatic tick();
    bit act, ok, is;
    longint c0;
    c0  = m_cmp;
    act = m_ph == 1 || m_ph == 2;
    ok  = num != 0 && src != 0 && stat != 0;
    is  = m_ph == 1 && !abort && !alm0 && !alm1 && (m_iss - c0) < MAXI && m_iss < m_num;
    e_serr = start && (m_ph != 0 || (!abort && !ok));
    e_done = m_ph == 3 && ready && !abort;
    e_rv   = is;
    if (is) begin e_addr = m_src + AW'(m_iss); e_md = m_iss[15:0]; end
    if (act && rsp_v) begin if (rsp_cl == 2'd2) m_perr = 1; else m_cmp += lines_of(rsp_cl); end
    if (act && c0 > m_num) m_perr = 1;
    if (act && m_cyc != '1) m_cyc++;
    if (abort && m_ph != 0) m_ph = 0;
    else if (m_ph == 0) begin
      if (start && !abort && ok) begin
        m_ph = 1; m_src = src; m_stat = stat; m_num = num; m_iss = 0; m_cmp = 0; m_cyc = 0; m_perr = 0;
      end
    end
    else if (m_ph == 1) begin if (is && m_iss + 1 == m_num) m_ph = 2; end
    else if (m_ph == 2) begin if (c0 >= m_num) m_ph = 3; end
    else if (ready) m_ph = 0;
    if (is) m_iss++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    start = 0; abort = 0; alm0 = 0; alm1 = 0; rsp_v = 0; ready = 0; rsp_cl = 0;
    rst_n = 0;
    m_ph = 0; m_src = 0; m_stat = 0; m_num = 0; m_iss = 0; m_cmp = 0; m_cyc = 0; m_perr = 0;
    e_rv = 0; e_done = 0; e_serr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({rd_v, rpt_v, busy, done, serr, perr} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {rd_v, rpt_v, busy, done, serr, perr}); end
    checks++; if (iss !== 0 || cmp !== 0) begin errors++; $display("FAIL reset_cnt got iss=%0d cmp=%0d exp 0/0", iss, cmp); end
    checks++; if (rpt_cyc !== 0 || rpt_addr !== 0 || rd_addr !== 0 || rd_md !== 0) begin errors++; $display("FAIL reset_data got cyc=%0h rpt=%0h rd=%0h md=%0h exp 0", rpt_cyc, rpt_addr, rd_addr, rd_md); end
    checks++; if ({s_rd_v, s_busy, s_rpt_v} !== 3'b0) begin errors++; $display("FAIL reset_small got %b exp 000", {s_rd_v, s_busy, s_rpt_v}); end
  endtask

  task automatic test_basic();
    do_reset();
    src = 42'h1000; stat = 42'h2000; num = 4; start = 1; tick(); start = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (rd_v !== 1'b1 || rd_addr !== 42'h1000 + 42'(k) || rd_md !== 16'(k)) begin errors++; $display("FAIL basic_read k=%0d got v=%b a=%0h md=%0h exp 1 %0h %0h", k, rd_v, rd_addr, rd_md, 42'h1000 + 42'(k), k); end
    end
    tick();
    checks++; if (rd_v !== 1'b0 || busy !== 1'b1 || iss !== 32'd4) begin errors++; $display("FAIL basic_drain got v=%b busy=%b iss=%0d exp 0 1 4", rd_v, busy, iss); end
    for (int k = 0; k < 4; k++) begin rsp_v = 1; rsp_cl = 0; tick(); end
    rsp_v = 0;
    for (int t = 0; t < 10 && !rpt_v; t++) tick();
    checks++; if (rpt_v !== 1'b1 || rpt_addr !== 42'h2000 || rpt_cyc !== 64'd10) begin errors++; $display("FAIL basic_report got v=%b a=%0h cyc=%0d exp 1 2000 10", rpt_v, rpt_addr, rpt_cyc); end
    repeat (2) tick();
    checks++; if (rpt_v !== 1'b1 || rpt_cyc !== 64'd10 || done !== 1'b0) begin errors++; $display("FAIL basic_hold got v=%b cyc=%0d done=%b exp 1 10 0", rpt_v, rpt_cyc, done); end
    ready = 1; tick(); ready = 0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || rpt_v !== 1'b0) begin errors++; $display("FAIL basic_done got done=%b busy=%b rpt=%b exp 1 0 0", done, busy, rpt_v); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_inflight();
    int cnt;
    do_reset();
    src = 42'h4000; stat = 42'h5000; num = 5; start = 1; tick(); start = 0;
    cnt = 0;
    repeat (10) begin tick(); cnt += int'(s_rd_v); end
    checks++; if (cnt !== 2) begin errors++; $display("FAIL inflight_cap got %0d reads exp 2", cnt); end
    for (int r = 0; r < 3; r++) begin
      rsp_v = 1; rsp_cl = 0; tick(); rsp_v = 0;
      cnt = int'(s_rd_v);
      repeat (8) begin tick(); cnt += int'(s_rd_v); end
      checks++; if (cnt !== 1) begin errors++; $display("FAIL inflight_release r=%0d got %0d reads exp 1", r, cnt); end
    end
    checks++; if (s_iss !== 32'd5) begin errors++; $display("FAIL inflight_total got %0d exp 5", s_iss); end
  endtask

  task automatic test_alm();
    do_reset();
    src = 42'h3_0000_0000; stat = 42'h77; num = 40; start = 1; tick(); start = 0;
    repeat (5) tick();
    alm0 = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (rd_v !== 1'b0) begin errors++; $display("FAIL alm_hold k=%0d got %b exp 0", k, rd_v); end
    end
    alm0 = 0; tick();
    checks++; if (rd_v !== 1'b1 || rd_md !== 16'd5 || rd_addr !== 42'h3_0000_0005) begin errors++; $display("FAIL alm_resume got v=%b md=%0d a=%0h exp 1 5 300000005", rd_v, rd_md, rd_addr); end
    abort = 1; tick(); abort = 0;
    checks++; if ({busy, rd_v, rpt_v, done} !== 4'b0 || iss !== 32'd6) begin errors++; $display("FAIL alm_abort got %b iss=%0d exp 0000 6", {busy, rd_v, rpt_v, done}, iss); end
  endtask

  task automatic test_proto_abort();
    do_reset();
    src = 42'h100; stat = 42'h200; num = 3; start = 1; tick(); start = 0;
    repeat (4) tick();
    rsp_v = 1; rsp_cl = 2; tick(); rsp_v = 0; rsp_cl = 0;
    checks++; if (perr !== 1'b1 || busy !== 1'b1 || cmp !== 32'd0) begin errors++; $display("FAIL proto_code2 got perr=%b busy=%b cmp=%0d exp 1 1 0", perr, busy, cmp); end
    abort = 1; tick(); abort = 0;
    checks++; if ({busy, done, rpt_v} !== 3'b0 || perr !== 1'b1) begin errors++; $display("FAIL proto_abort got %b perr=%b exp 000 1", {busy, done, rpt_v}, perr); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL proto_nodone got %b exp 0", done); end
    num = 0; start = 1; tick(); start = 0;
    checks++; if (serr !== 1'b1 || busy !== 1'b0 || perr !== 1'b1) begin errors++; $display("FAIL proto_zero_start got serr=%b busy=%b perr=%b exp 1 0 1", serr, busy, perr); end
    tick();
    checks++; if (serr !== 1'b0) begin errors++; $display("FAIL proto_serr_pulse got %b exp 0", serr); end
  endtask

  task automatic test_start_rules();
    do_reset();
    src = 42'h10; stat = 42'h20; num = 8; start = 1; abort = 1; tick(); start = 0; abort = 0;
    checks++; if (busy !== 1'b0 || serr !== 1'b0) begin errors++; $display("FAIL start_abort_idle got busy=%b serr=%b exp 0 0", busy, serr); end
    start = 1; tick(); start = 0;
    checks++; if (busy !== 1'b1 || serr !== 1'b0) begin errors++; $display("FAIL start_accept got busy=%b serr=%b exp 1 0", busy, serr); end
    start = 1; tick(); start = 0;
    checks++; if (serr !== 1'b1 || busy !== 1'b1 || iss !== m_iss[31:0]) begin errors++; $display("FAIL start_busy got serr=%b busy=%b iss=%0d exp 1 1 %0d", serr, busy, iss, m_iss); end
    abort = 1; tick(); abort = 0;
    src = 0; start = 1; tick(); start = 0;
    checks++; if (serr !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL start_src0 got serr=%b busy=%b exp 1 0", serr, busy); end
  endtask

  task automatic test_wrap();
    logic [15:0] prev;
    bit wrapped, seen;
    int bad;
    do_reset();
    src = {10'($urandom), $urandom} | 42'h1; stat = 42'hABC; num = 32'h10010; start = 1; tick(); start = 0;
    wrapped = 0; seen = 0; bad = 0; prev = 0;
    for (int t = 0; t < 70000 && !rpt_v; t++) begin
      tick();
      checks++; if (rd_v !== e_rv || (e_rv && (rd_addr !== e_addr || rd_md !== e_md))) begin errors++; bad++; if (bad < 10) $display("FAIL wrap_read t=%0d got v=%b md=%0h exp %b %0h", t, rd_v, rd_md, e_rv, e_md); end
      if (rd_v) begin
        if (seen && prev == 16'hFFFF && rd_md == 16'h0000) wrapped = 1;
        prev = rd_md; seen = 1;
      end
      rsp_v = rd_v; rsp_cl = 0;
    end
    rsp_v = 0;
    checks++; if (!wrapped) begin errors++; $display("FAIL wrap_mdata got no FFFF->0000 transition exp one"); end
    checks++; if (rpt_v !== 1'b1 || cmp !== 32'h10010 || perr !== 1'b0) begin errors++; $display("FAIL wrap_report got rpt=%b cmp=%0h perr=%b exp 1 10010 0", rpt_v, cmp, perr); end
    ready = 1; tick(); ready = 0;
  endtask

  task automatic test_random();
    int pend, c, ln;
    bit fin;
    for (int j = 0; j < 6; j++) begin
      do_reset();
      src = j == 0 ? '1 - 42'd5 : ({10'($urandom), $urandom} | 42'h1);
      stat = {10'($urandom), $urandom} | 42'h1;
      num = $urandom_range(1, 150);
      start = 1; tick(); start = 0;
      pend = 0; fin = 0;
      for (int t = 0; t < 4000 && !fin; t++) begin
        alm0 = $urandom_range(0, 3) == 0; alm1 = $urandom_range(0, 5) == 0;
        ready = $urandom_range(0, 2) == 0;
        tick();
        checks++; if (rd_v !== e_rv || (e_rv && (rd_addr !== e_addr || rd_md !== e_md))) begin errors++; $display("FAIL rand_read j=%0d t=%0d got v=%b a=%0h md=%0h exp %b %0h %0h", j, t, rd_v, rd_addr, rd_md, e_rv, e_addr, e_md); end
        checks++; if (busy !== (m_ph != 0) || rpt_v !== (m_ph == 3) || done !== e_done) begin errors++; $display("FAIL rand_ctrl j=%0d t=%0d got busy=%b rpt=%b done=%b exp ph=%0d done=%b", j, t, busy, rpt_v, done, m_ph, e_done); end
        checks++; if (iss !== m_iss[31:0] || cmp !== m_cmp[31:0] || perr !== m_perr) begin errors++; $display("FAIL rand_cnt j=%0d t=%0d got iss=%0d cmp=%0d perr=%b exp %0d %0d %b", j, t, iss, cmp, perr, m_iss, m_cmp, m_perr); end
        if (rpt_v) begin
          checks++; if (rpt_addr !== m_stat || rpt_cyc !== m_cyc) begin errors++; $display("FAIL rand_rpt j=%0d got a=%0h cyc=%0d exp %0h %0d", j, rpt_addr, rpt_cyc, m_stat, m_cyc); end
        end
        if (done) fin = 1;
        if (rd_v) pend++;
        rsp_v = 0;
        if (pend > 0 && $urandom_range(0, 2) == 0) begin
          c = $urandom_range(0, 2);
          rsp_cl = (c == 2 && pend >= 4) ? 2'd3 : (c >= 1 && pend >= 2) ? 2'd1 : 2'd0;
          ln = lines_of(rsp_cl);
          pend -= ln; rsp_v = 1;
        end
      end
      alm0 = 0; alm1 = 0; ready = 0; rsp_v = 0;
      checks++; if (!fin) begin errors++; $display("FAIL rand_timeout j=%0d got no done exp done within budget", j); end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    src = 42'h900; stat = 42'h901; num = 50; start = 1; tick(); start = 0;
    repeat (5) tick();
    #2 rst_n = 0;
    #1;
    checks++; if ({rd_v, busy, rpt_v, done, perr} !== 5'b0 || iss !== 0 || cmp !== 0 || rd_addr !== 0 || rpt_cyc !== 0) begin errors++; $display("FAIL rstmid_async got flags=%b iss=%0d cmp=%0d a=%0h exp all 0", {rd_v, busy, rpt_v, done, perr}, iss, cmp, rd_addr); end
    @(posedge clk); #1 rst_n = 1;
    m_ph = 0;
    bad = 0;
    rsp_v = 1; rsp_cl = 0; ready = 1;
    repeat (60) begin tick(); if (rpt_v || done || rd_v || busy) bad++; end
    rsp_v = 0; ready = 0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_noreport got %0d active cycles exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inflight();
    test_alm();
    test_proto_abort();
    test_start_rules();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
